// File: rtl/popcount_dot_accumulator.sv
// Accumulates per-word XNOR popcounts over a group closed by in_last (or MAX_WORDS)
// and emits the group's signed binary dot product (2*sum - BITS*words) through a one-slot output.
module popcount_dot_accumulator #(
   parameter int POP_W     = 7,
   parameter int BITS      = 64,
   parameter int MAX_WORDS = 256,
   parameter int SUM_W     = 16,
   parameter int CNT_W     = 9
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [POP_W-1:0]   in_pop,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SUM_W+1:0]   out_dot,
   output logic [CNT_W-1:0]   out_words,
   output logic               out_err,
   output logic               dbg_state_o
);

   // Handshake: a word transfers on a rising edge where in_valid & in_ready;
   // a result transfers on a rising edge where out_valid & out_ready.
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [SUM_W-1:0]   sum_q, sum_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               out_valid_q, out_valid_d;
   logic [SUM_W+1:0]   out_dot_q, out_dot_d;
   logic [CNT_W-1:0]   out_words_q, out_words_d;
   logic               out_err_q, out_err_d;

   logic               accept;
   logic               closing;
   logic [SUM_W-1:0]   grp_sum;
   logic [CNT_W-1:0]   grp_cnt;
   logic [SUM_W+1:0]   bias;

   assign accept  = in_valid & in_ready;
   assign grp_sum = sum_q + SUM_W'(in_pop);
   assign grp_cnt = cnt_q + CNT_W'(1);
   assign closing = in_last | (grp_cnt == CNT_W'(MAX_WORDS));
   assign bias    = (SUM_W+2)'(BITS) * (SUM_W+2)'(grp_cnt);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (accept) begin
         if (closing) state_d = ST_IDLE;
         else         state_d = ST_ACCUM;
      end
   end

   // FSM outputs
   always_comb begin
      in_ready    = ~out_valid_q | out_ready;
      dbg_state_o = state_q;
   end

   // Datapath next state
   always_comb begin
      sum_d       = sum_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_dot_d   = out_dot_q;
      out_words_d = out_words_q;
      out_err_d   = out_err_q;
      if (out_valid_q & out_ready) out_valid_d = 1'b0;
      if (accept) begin
         if (closing) begin
            // Sum is unsigned, so zero-extend before doubling into the signed result.
            out_dot_d   = {1'b0, grp_sum, 1'b0} - bias;
            out_words_d = grp_cnt;
            out_err_d   = ~in_last;
            out_valid_d = 1'b1;
            sum_d       = '0;
            cnt_d       = '0;
         end else begin
            sum_d = grp_sum;
            cnt_d = grp_cnt;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_dot_q   <= '0;
         out_words_q <= '0;
         out_err_q   <= 1'b0;
      end else begin
         sum_q       <= sum_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_dot_q   <= out_dot_d;
         out_words_q <= out_words_d;
         out_err_q   <= out_err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_dot   = out_dot_q;
   assign out_words = out_words_q;
   assign out_err   = out_err_q;

endmodule
